// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap_pkg                                                            |
// | Shared operation encodings for the SAP core datapath registers.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package sap_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLRC = 3'b111;

endpackage : sap_pkg
`default_nettype wire

// File: rtl/reg_universal_next.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_universal_next                                                 |
// | Combinational next-state function of the universal register.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module reg_universal_next
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          WRAP       = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_carry,
  input  logic [DATA_WIDTH-1:0] i_d,
  input  logic                  i_sin,
  input  logic [MODE_W-1:0]     i_mode,
  output logic [DATA_WIDTH-1:0] o_next_q,
  output logic                  o_next_carry
);

  localparam logic [DATA_WIDTH-1:0] C_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic w_all_ones;
  logic w_is_zero;

  assign w_all_ones = &i_q;
  assign w_is_zero  = ~|i_q;

  always_comb begin
    o_next_q     = i_q;
    o_next_carry = i_carry;
    case (i_mode)
      MODE_LOAD: begin
        o_next_q     = i_d;
        o_next_carry = 1'b0;
      end
      MODE_INC: begin
        o_next_carry = w_all_ones;
        // Saturating variant pins at all-ones but still flags the overflow
        if (WRAP || !w_all_ones) o_next_q = i_q + C_ONE;
      end
      MODE_DEC: begin
        o_next_carry = w_is_zero;
        if (WRAP || !w_is_zero) o_next_q = i_q - C_ONE;
      end
      MODE_SHL: begin
        o_next_q     = {i_q[DATA_WIDTH-2:0], i_sin};
        o_next_carry = i_q[DATA_WIDTH-1];
      end
      MODE_SHR: begin
        o_next_q     = {i_sin, i_q[DATA_WIDTH-1:1]};
        o_next_carry = i_q[0];
      end
      MODE_ROL: begin
        o_next_q     = {i_q[DATA_WIDTH-2:0], i_q[DATA_WIDTH-1]};
        o_next_carry = i_q[DATA_WIDTH-1];
      end
      MODE_ROR: begin
        o_next_q     = {i_q[0], i_q[DATA_WIDTH-1:1]};
        o_next_carry = i_q[0];
      end
      MODE_CLRC: begin
        o_next_carry = 1'b0;
      end
      default: begin
        o_next_q     = i_q;
        o_next_carry = i_carry;
      end
    endcase
  end

endmodule : reg_universal_next
`default_nettype wire

// File: rtl/reg_universal.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_universal                                                      |
// | Multi-mode datapath register: load, count, shift, rotate, W-bus.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module reg_universal
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_en,
  input  logic [MODE_W-1:0]     i_mode,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  i_sin,
  input  logic                  i_out_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] qbar,
  output logic [DATA_WIDTH-1:0] o_bus,
  output logic                  o_carry,
  output logic                  o_zero
);

  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_carry;
  logic [DATA_WIDTH-1:0] w_next_q;
  logic                  w_next_carry;

  reg_universal_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRAP       (WRAP)
  ) u_next (
    .i_q          (r_q),
    .i_carry      (r_carry),
    .i_d          (d),
    .i_sin        (i_sin),
    .i_mode       (i_mode),
    .o_next_q     (w_next_q),
    .o_next_carry (w_next_carry)
  );

  // clr outranks i_en, which outranks the selected mode
  always_ff @(posedge clk) begin
    if (clr) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_q     <= w_next_q;
      r_carry <= w_next_carry;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign o_carry = r_carry;
  assign o_zero  = ~|r_q;
  // Zero when disabled so several registers can be OR-ed onto the W bus
  assign o_bus   = i_out_en ? r_q : '0;

endmodule : reg_universal
`default_nettype wire

// File: tb/tb_reg_universal.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_universal                                                   |
// | Directed bench for wrapping and saturating reg_universal.          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_reg_universal;
  import sap_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic         out_en;

  logic [W-1:0] wq, wqbar, wbus, sq, sqbar, sbus;
  logic         wc, wz, sc, sz;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_universal #(.DATA_WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .clr(clr), .i_en(en), .i_mode(mode), .d(d), .i_sin(sin),
    .i_out_en(out_en), .q(wq), .qbar(wqbar), .o_bus(wbus),
    .o_carry(wc), .o_zero(wz)
  );

  reg_universal #(.DATA_WIDTH(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .clr(clr), .i_en(en), .i_mode(mode), .d(d), .i_sin(sin),
    .i_out_en(out_en), .q(sq), .qbar(sqbar), .o_bus(sbus),
    .o_carry(sc), .o_zero(sz)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] eq, input logic ec);
    chk({tag, ".wrap.q"}, wq, eq);
    chk({tag, ".wrap.c"}, {7'd0, wc}, {7'd0, ec});
    chk({tag, ".wrap.z"}, {7'd0, wz}, {7'd0, (eq == '0)});
  endtask

  task automatic chk_s(input string tag, input logic [W-1:0] eq, input logic ec);
    chk({tag, ".sat.q"}, sq, eq);
    chk({tag, ".sat.c"}, {7'd0, sc}, {7'd0, ec});
    chk({tag, ".sat.z"}, {7'd0, sz}, {7'd0, (eq == '0)});
  endtask

  // Apply one edge with the given controls, then settle before checking
  task automatic step(input logic c, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dv, input logic s);
    clr = c; en = e; mode = m; d = dv; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; mode = MODE_LOAD; d = '0; sin = 1'b0; out_en = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
    chk_w("rst", 8'h00, 1'b0);
    chk_s("rst", 8'h00, 1'b0);
    chk("rst.wrap.qbar", wqbar, 8'hFF);
    chk("rst.sat.qbar", sqbar, 8'hFF);
    chk("rst.wrap.bus", wbus, 8'h00);

    // Count up across the all-ones boundary
    step(1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0);
    chk_w("ldFE", 8'hFE, 1'b0);
    chk("ldFE.qbar", wqbar, 8'h01);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("inc1", 8'hFF, 1'b0);
    chk_s("inc1", 8'hFF, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("inc2", 8'h00, 1'b1);
    chk_s("inc2", 8'hFF, 1'b1);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("inc3", 8'h01, 1'b0);
    chk_s("inc3", 8'hFF, 1'b1);

    // Count down across zero
    step(1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    chk_s("dec1", 8'h00, 1'b0);
    chk_w("dec1", 8'h00, 1'b0);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    chk_s("dec2", 8'h00, 1'b1);
    chk_w("dec2", 8'hFF, 1'b1);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    chk_s("dec3", 8'h00, 1'b1);
    chk_w("dec3", 8'hFE, 1'b0);
    step(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_s("incFF", 8'hFF, 1'b1);
    chk_w("incFF", 8'h00, 1'b1);

    // Shifts and rotates
    step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
    step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1);
    chk_w("shl", 8'h03, 1'b1);
    step(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0);
    chk_w("ror", 8'h81, 1'b1);
    step(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0);
    chk_w("shr", 8'h40, 1'b1);
    step(1'b0, 1'b1, MODE_CLRC, 8'hFF, 1'b1);
    chk_w("clrc", 8'h40, 1'b0);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    chk_w("dec40", 8'h3F, 1'b0);
    step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
    step(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0);
    chk_w("rol", 8'h03, 1'b1);
    step(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b1);
    chk_w("rol2", 8'h06, 1'b0);

    // Hold while disabled, with carry set and every mode presented
    step(1'b0, 1'b1, MODE_LOAD, 8'hAB, 1'b0);
    step(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0);
    chk_w("shrAB", 8'h55, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'(2 * i), 8'h00, 1'b1);
      step(1'b0, 1'b0, 3'(2 * i + 1), 8'h00, 1'b1);
    end
    chk_w("hold", 8'h55, 1'b1);
    chk("hold.qbar", wqbar, 8'hAA);

    // Bus gating is combinational
    out_en = 1'b0; #1;
    chk("bus.off", wbus, 8'h00);
    out_en = 1'b1; #1;
    chk("bus.on", wbus, 8'h55);
    out_en = 1'b0; #1;
    chk("bus.off2", wbus, 8'h00);
    out_en = 1'b1; #1;

    // Clear in the middle of a count run
    step(1'b0, 1'b1, MODE_LOAD, 8'h0F, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("run", 8'h10, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("midclr", 8'h00, 1'b0);
    chk_s("midclr", 8'h00, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    chk_w("resume", 8'h01, 1'b0);
    chk("resume.bus", wbus, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_universal
`default_nettype wire
